// File: rtl/arb_req.sv
// arb_req: per-port request controller in front of one priority-arbiter input.
// Buffers incoming words in a 2^AW-deep FIFO, raises req once a complete
// packet is stored, and streams that packet one word per granted cycle.
// req is held for the whole packet (grant may be withdrawn mid-packet) and
// drops for exactly one cycle between packets.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous reset, active-low
//   in_valid   input word valid
//   in_ready   FIFO can accept a word (!full)
//   in_data    input word
//   in_last    input word ends its packet
//   req        registered request to the arbiter
//   grt        grant from the arbiter (combinational from req)
//   out_valid  registered output word valid
//   out_data   registered output word
//   out_last   registered end-of-packet
//   err        sticky: FIFO full with no complete packet stored
module arb_req #(
  parameter int DW = 64,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          req,
  input  logic          grt,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          err
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e          state_q;
  logic            req_q;
  logic [DW:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [AW:0]     pkt_cnt_q, pkt_cnt_d;
  logic            out_valid_q, out_last_q, err_q;
  logic [DW-1:0]   out_data_q;

  logic            full, push, pop;
  logic [DW:0]     head;
  logic            head_last;

  assign full      = (count_q == DEPTH_C);
  assign push      = in_valid & ~full;           // never push when full, even while popping
  assign pop       = (state_q == REQ) & grt;
  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[DW];

  always_comb begin
    count_d   = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    pkt_cnt_d = pkt_cnt_q + (AW + 1)'(push & in_last) - (AW + 1)'(pop & head_last);
  end

  // Storage array carries no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      pkt_cnt_q   <= pkt_cnt_d;
      out_valid_q <= pop;
      if (pop) begin
        out_data_q <= head[DW-1:0];
        out_last_q <= head_last;
      end
      // A full FIFO without a complete packet can never drain: deadlock flag.
      if (full && (pkt_cnt_q == '0)) err_q <= 1'b1;
    end
  end

  // Request FSM; req is registered alongside the state so it is glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((pkt_cnt_q != '0) && !err_q) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (grt && head_last) begin
            state_q <= GAP;
            req_q   <= 1'b0;
          end
        end
        GAP: begin
          // pkt_cnt_d includes a last word arriving during the gap cycle.
          if ((pkt_cnt_d != '0) && !err_q) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ~full;
  assign req       = req_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_arb_req.sv
// Directed testbench for arb_req: basic packet transfer, back-to-back packets,
// preemption, full FIFO back-pressure, error flag, and asynchronous reset.
module tb_arb_req;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        req;
  logic        grt;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_last;
  logic        err;

  logic        tie;
  logic        grt_man;

  int errors = 0;
  int checks = 0;

  assign grt = tie ? req : grt_man;

  arb_req #(.DW(64), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .req       (req),
    .grt       (grt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  logic        pat  [6];
  logic        xov  [6];
  logic [63:0] xdat [6];
  logic        xlst [6];
  int          got;

  initial begin
    rst = 1'b1; tie = 1'b0; grt_man = 1'b0;
    idle_in();
    #1 rst = 1'b0;
    #1;
    // ---------------- reset values ----------------
    chk("rst_req",       req,       1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data,  64'h0);
    chk("rst_out_last",  out_last,  1'b0);
    chk("rst_err",       err,       1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    step(); step();
    rst = 1'b1;

    // ---------------- 3-word packet, grt tied to req ----------------
    tie = 1'b1;
    step(); push(64'hA, 1'b0);               // cycle 1
    step(); push(64'hB, 1'b0);               // cycle 2
    step(); push(64'hC, 1'b1);               // cycle 3
    step(); idle_in();                       // cycle 4
    chk("p1_c4_req", req, 1'b0);
    step();                                  // cycle 5
    chk("p1_c5_req", req, 1'b1);
    chk("p1_c5_ov",  out_valid, 1'b0);
    step();                                  // cycle 6
    chk("p1_c6_ov",  out_valid, 1'b1);
    chk("p1_c6_d",   out_data, 64'hA);
    chk("p1_c6_l",   out_last, 1'b0);
    step();                                  // cycle 7
    chk("p1_c7_ov",  out_valid, 1'b1);
    chk("p1_c7_d",   out_data, 64'hB);
    chk("p1_c7_l",   out_last, 1'b0);
    step();                                  // cycle 8
    chk("p1_c8_ov",  out_valid, 1'b1);
    chk("p1_c8_d",   out_data, 64'hC);
    chk("p1_c8_l",   out_last, 1'b1);
    chk("p1_c8_req", req, 1'b0);
    step();                                  // cycle 9
    chk("p1_c9_req", req, 1'b0);
    chk("p1_c9_ov",  out_valid, 1'b0);
    chk("p1_c9_hold", out_data, 64'hC);

    // ---------------- two 2-word packets back to back ----------------
    tie = 1'b0; grt_man = 1'b0;
    step(); push(64'h11, 1'b0);              // cycle 1
    step(); push(64'h12, 1'b1);              // cycle 2
    step(); push(64'h13, 1'b0);              // cycle 3
    step(); push(64'h14, 1'b1);              // cycle 4
    step(); idle_in();                       // cycle 5
    step();                                  // cycle 6
    chk("bb_c6_req", req, 1'b1);
    chk("bb_c6_ov",  out_valid, 1'b0);
    tie = 1'b1;
    step();                                  // cycle 7
    chk("bb_c7_ov", out_valid, 1'b1);
    chk("bb_c7_d",  out_data, 64'h11);
    chk("bb_c7_l",  out_last, 1'b0);
    step();                                  // cycle 8
    chk("bb_c8_d",   out_data, 64'h12);
    chk("bb_c8_l",   out_last, 1'b1);
    chk("bb_c8_req", req, 1'b0);
    step();                                  // cycle 9
    chk("bb_c9_req", req, 1'b1);
    chk("bb_c9_ov",  out_valid, 1'b0);
    step();                                  // cycle 10
    chk("bb_c10_ov", out_valid, 1'b1);
    chk("bb_c10_d",  out_data, 64'h13);
    chk("bb_c10_l",  out_last, 1'b0);
    step();                                  // cycle 11
    chk("bb_c11_d",   out_data, 64'h14);
    chk("bb_c11_l",   out_last, 1'b1);
    chk("bb_c11_req", req, 1'b0);
    step();                                  // cycle 12
    chk("bb_c12_req", req, 1'b0);
    chk("bb_c12_ov",  out_valid, 1'b0);

    // ---------------- preemption ----------------
    tie = 1'b0; grt_man = 1'b0;
    step(); push(64'h20, 1'b0);
    step(); push(64'h21, 1'b0);
    step(); push(64'h22, 1'b0);
    step(); push(64'h23, 1'b1);
    step(); idle_in();
    step();                                  // req expected high now
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    xov  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    xdat = '{64'h20, 64'h20, 64'h20, 64'h21, 64'h22, 64'h23};
    xlst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      grt_man = pat[i];
      chk($sformatf("pre_req_%0d", i), req, 1'b1);
      step();
      chk($sformatf("pre_ov_%0d", i), out_valid, xov[i]);
      chk($sformatf("pre_d_%0d", i),  out_data, xdat[i]);
      chk($sformatf("pre_l_%0d", i),  out_last, xlst[i]);
    end
    grt_man = 1'b0;
    chk("pre_gap_req", req, 1'b0);
    step(); step();

    // ---------------- fill to full, extra pushes ignored ----------------
    tie = 1'b0; grt_man = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 15) chk("full_ready_at15", in_ready, 1'b1);
      push(64'h400 + 64'(i), (i % 4) == 3);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("full_ready_%0d", i), in_ready, 1'b0);
      push(64'hDEAD, 1'b1);
      if (i == 2) grt_man = 1'b1;
    end
    chk("full_err", err, 1'b0);
    step();
    grt_man = 1'b0;
    idle_in();
    chk("drain_ready", in_ready, 1'b1);
    chk("drain_ov",    out_valid, 1'b1);
    chk("drain_d0",    out_data, 64'h400);
    tie = 1'b1;
    got = 1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (out_valid) begin
        chk($sformatf("drain_d%0d", got), out_data, 64'h400 + 64'(got));
        chk($sformatf("drain_l%0d", got), out_last, (got % 4) == 3);
        got++;
      end
    end
    chk("drain_count", 64'(got), 64'd16);
    chk("drain_idle_req", req, 1'b0);

    // ---------------- err: full without a complete packet ----------------
    rst = 1'b0;
    #1;
    step();
    rst = 1'b1;
    tie = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      push(64'h500 + 64'(i), 1'b0);
    end
    step(); idle_in();                       // cycle 17: full
    chk("err_c17_ready", in_ready, 1'b0);
    chk("err_c17_err",   err, 1'b0);
    step();                                  // cycle 18
    chk("err_c18_err", err, 1'b1);
    chk("err_c18_req", req, 1'b0);
    step();
    chk("err_c19_req", req, 1'b0);
    chk("err_c19_err", err, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("err_rst_err",   err, 1'b0);
    chk("err_rst_ready", in_ready, 1'b1);
    step();
    rst = 1'b1;

    // ---------------- async reset mid-packet ----------------
    tie = 1'b1;
    step(); push(64'hA1, 1'b0);
    step(); push(64'hA2, 1'b0);
    step(); push(64'hA3, 1'b1);
    step(); idle_in();
    step();
    chk("ar_req_hi", req, 1'b1);
    step();
    chk("ar_ov_hi", out_valid, 1'b1);
    chk("ar_d",     out_data, 64'hA1);
    #3 rst = 1'b0;
    #1;
    chk("ar_req_lo", req, 1'b0);
    chk("ar_ov_lo",  out_valid, 1'b0);
    chk("ar_d_lo",   out_data, 64'h0);
    #2 rst = 1'b1;
    step(); push(64'hE0, 1'b0);              // cycle 1
    step(); push(64'hF0, 1'b1);              // cycle 2
    step(); idle_in();                       // cycle 3
    chk("ar2_c3_req", req, 1'b0);
    chk("ar2_c3_ov",  out_valid, 1'b0);
    step();                                  // cycle 4
    chk("ar2_c4_req", req, 1'b1);
    step();                                  // cycle 5
    chk("ar2_c5_ov", out_valid, 1'b1);
    chk("ar2_c5_d",  out_data, 64'hE0);
    step();                                  // cycle 6
    chk("ar2_c6_ov", out_valid, 1'b1);
    chk("ar2_c6_d",  out_data, 64'hF0);
    chk("ar2_c6_l",  out_last, 1'b1);
    step();
    chk("ar2_c7_ov", out_valid, 1'b0);
    step();
    chk("ar2_c8_req", req, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
